// File: rtl/core_clock_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the core clock request block.
package core_clock_pkg;

  localparam int unsigned CORE_CLK_HOLD_DEFAULT = 4;
  localparam int unsigned CORE_CLK_WAKE_DEFAULT = 2;
  localparam int unsigned CORE_CLK_CNT_MAX      = 15;

  typedef enum logic [1:0] {
    CLK_ST_RUN   = 2'd0,
    CLK_ST_DRAIN = 2'd1,
    CLK_ST_SLEEP = 2'd2,
    CLK_ST_WAKE  = 2'd3
  } core_clk_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned core_clk_cnt_w(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/core_clock_hold.sv
// Per-unit clock request hold-off: keeps a request alive for HOLD_CYCLES after the last active cycle.
module core_clock_hold
  import core_clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = CORE_CLK_HOLD_DEFAULT
) (
  input  logic f_clk,
  input  logic g_resetn,
  input  logic active,
  input  logic flush,
  output logic hold_nz
);

  localparam int unsigned      CNT_W    = core_clk_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Flush beats activity so a sleep entry always leaves the counter empty.
  always_comb begin
    cnt_next = cnt;
    if (flush) begin
      cnt_next = '0;
    end else if (active) begin
      cnt_next = CNT_LOAD;
    end else if (cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      cnt     <= '0;
      hold_nz <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      hold_nz <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/core_clock_req.sv
// Core clock request controller: RUN/DRAIN/SLEEP/WAKE sequencing plus per-unit gated clock requests.
// Define CORE_CLOCK_HOLD_EN to keep unit requests alive for HOLD_CYCLES after activity ends.
module core_clock_req
  import core_clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = CORE_CLK_HOLD_DEFAULT,
  parameter int unsigned WAKE_CYCLES = CORE_CLK_WAKE_DEFAULT
) (
  input  logic f_clk,
  input  logic g_resetn,
  input  logic wfi_req,
  input  logic core_idle,
  input  logic wakeup,
  input  logic rf_active,
  input  logic mul_start,
  input  logic mul_busy,
  output logic g_clk_req,
  output logic g_clk_rf_req,
  output logic g_clk_mul_req,
  output logic core_sleeping
);

  localparam logic [1:0] ST_RUN   = 2'(CLK_ST_RUN);
  localparam logic [1:0] ST_DRAIN = 2'(CLK_ST_DRAIN);
  localparam logic [1:0] ST_SLEEP = 2'(CLK_ST_SLEEP);
  localparam logic [1:0] ST_WAKE  = 2'(CLK_ST_WAKE);

  localparam int unsigned      WAKE_W    = core_clk_cnt_w(CORE_CLK_CNT_MAX);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES);

  // Elaboration-time parameter range checks.
  if (HOLD_CYCLES < 32'd1 || HOLD_CYCLES > CORE_CLK_CNT_MAX) begin : g_bad_hold
    $error("core_clock_req: HOLD_CYCLES outside 1..15");
  end
  if (WAKE_CYCLES < 32'd1 || WAKE_CYCLES > CORE_CLK_CNT_MAX) begin : g_bad_wake
    $error("core_clock_req: WAKE_CYCLES outside 1..15");
  end

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [WAKE_W-1:0] wake_cnt;
  logic [WAKE_W-1:0] wake_cnt_next;
  logic              rf_hold_nz;
  logic              mul_hold_nz;
  logic              in_sleep;

  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      state         <= ST_RUN;
      wake_cnt      <= '0;
      core_sleeping <= 1'b0;
    end else begin
      state         <= state_next;
      wake_cnt      <= wake_cnt_next;
      core_sleeping <= (state_next == ST_SLEEP);
    end
  end

  // Wakeup outranks both sleep request and drain completion.
  always_comb begin
    state_next    = state;
    wake_cnt_next = wake_cnt;
    case (state)
      ST_RUN: begin
        if (wfi_req && !wakeup) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wakeup) begin
          state_next = ST_RUN;
        end else if (core_idle) begin
          state_next = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (wakeup) begin
          state_next    = ST_WAKE;
          wake_cnt_next = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt <= WAKE_W'(1)) begin
          state_next    = ST_RUN;
          wake_cnt_next = '0;
        end else begin
          wake_cnt_next = wake_cnt - WAKE_W'(1);
        end
      end
      default: begin
        state_next    = ST_RUN;
        wake_cnt_next = '0;
      end
    endcase
  end

`ifdef CORE_CLOCK_HOLD_EN
  logic sleep_flush;

  // Counters stay clear for the whole sleep so WAKE always starts from zero.
  assign sleep_flush = (state_next == ST_SLEEP);

  core_clock_hold #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_rf_hold (
    .f_clk    (f_clk),
    .g_resetn (g_resetn),
    .active   (rf_active),
    .flush    (sleep_flush),
    .hold_nz  (rf_hold_nz)
  );

  core_clock_hold #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_mul_hold (
    .f_clk    (f_clk),
    .g_resetn (g_resetn),
    .active   (mul_start || mul_busy),
    .flush    (sleep_flush),
    .hold_nz  (mul_hold_nz)
  );
`else
  assign rf_hold_nz  = 1'b0;
  assign mul_hold_nz = 1'b0;
`endif

  // Requests are forced on during reset so every domain sees reset edges.
  assign in_sleep      = (state == ST_SLEEP);
  assign g_clk_req     = !in_sleep || !g_resetn;
  assign g_clk_rf_req  = ((rf_active || rf_hold_nz) && !in_sleep) || !g_resetn;
  assign g_clk_mul_req = ((mul_start || mul_busy || mul_hold_nz) && !in_sleep) || !g_resetn;

endmodule

// File: tb/tb_core_clock_req.sv
// Scoreboard bench for core_clock_req (default parameters); hold expectations follow CORE_CLOCK_HOLD_EN.
module tb_core_clock_req;
  import core_clock_pkg::*;

`ifdef CORE_CLOCK_HOLD_EN
  localparam logic H = 1'b1;
`else
  localparam logic H = 1'b0;
`endif

  localparam logic [1:0] RUN = 2'(CLK_ST_RUN);
  localparam logic [1:0] DRN = 2'(CLK_ST_DRAIN);
  localparam logic [1:0] SLP = 2'(CLK_ST_SLEEP);
  localparam logic [1:0] WAK = 2'(CLK_ST_WAKE);

  logic f_clk = 1'b0;
  logic g_resetn, wfi_req, core_idle, wakeup, rf_active, mul_start, mul_busy;
  logic g_clk_req, g_clk_rf_req, g_clk_mul_req, core_sleeping;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       sl;
    logic       cr;
    logic       rr;
    logic       mr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;

  core_clock_req dut (
    .f_clk         (f_clk),
    .g_resetn      (g_resetn),
    .wfi_req       (wfi_req),
    .core_idle     (core_idle),
    .wakeup        (wakeup),
    .rf_active     (rf_active),
    .mul_start     (mul_start),
    .mul_busy      (mul_busy),
    .g_clk_req     (g_clk_req),
    .g_clk_rf_req  (g_clk_rf_req),
    .g_clk_mul_req (g_clk_mul_req),
    .core_sleeping (core_sleeping)
  );

  always #5 f_clk = ~f_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs and queue what the outputs must be during that cycle.
  task automatic drive(input string tag,
                       input logic rn, input logic wfi, input logic idle, input logic wk,
                       input logic rf, input logic ms, input logic mb,
                       input logic [1:0] st, input logic sl,
                       input logic cr, input logic rr, input logic mr);
    g_resetn  = rn;
    wfi_req   = wfi;
    core_idle = idle;
    wakeup    = wk;
    rf_active = rf;
    mul_start = ms;
    mul_busy  = mb;
    exp_q.push_back({st, sl, cr, rr, mr});
    tag_q.push_back(tag);
    @(posedge f_clk);
    #1;
  endtask

  always @(negedge f_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check_eq({mon_t, ".state"}, 32'(dut.state),     32'(mon_e.st));
      check_eq({mon_t, ".sleep"}, 32'(core_sleeping), 32'(mon_e.sl));
      check_eq({mon_t, ".clk"},   32'(g_clk_req),     32'(mon_e.cr));
      check_eq({mon_t, ".rf"},    32'(g_clk_rf_req),  32'(mon_e.rr));
      check_eq({mon_t, ".mul"},   32'(g_clk_mul_req), 32'(mon_e.mr));
    end
  end

  initial begin
    g_resetn = 1'b0; wfi_req = 1'b0; core_idle = 1'b0; wakeup = 1'b0;
    rf_active = 1'b0; mul_start = 1'b0; mul_busy = 1'b0;
    @(posedge f_clk);
    #1;

    // Reset: all requests forced high, then idle RUN.
    drive("rst",   0, 0,0,0, 0,0,0, RUN, 0, 1,1,1);
    drive("idle0", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("idle1", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    // Sleep entry/exit with activity on the entry cycle and gated activity while asleep.
    drive("slp_c0", 1, 1,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("slp_c1", 1, 1,0,0, 0,0,0, DRN, 0, 1,0,0);
    drive("slp_c2", 1, 1,0,0, 0,0,0, DRN, 0, 1,0,0);
    drive("slp_c3", 1, 1,1,0, 0,1,0, DRN, 0, 1,0,1);
    drive("slp_c4", 1, 1,1,0, 0,0,0, SLP, 1, 0,0,0);
    drive("slp_c5", 1, 0,0,0, 1,0,0, SLP, 1, 0,0,0);
    drive("slp_c6", 1, 0,0,0, 0,0,1, SLP, 1, 0,0,0);
    for (int i = 7; i < 10; i++)
      drive($sformatf("slp_c%0d", i), 1, 0,0,0, 0,0,0, SLP, 1, 0,0,0);
    drive("slp_c10", 1, 0,0,1, 0,0,0, SLP, 1, 0,0,0);
    drive("slp_c11", 1, 1,0,1, 0,0,0, WAK, 0, 1,0,0);
    drive("slp_c12", 1, 1,0,0, 0,0,0, WAK, 0, 1,0,0);
    drive("slp_c13", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("slp_c14", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    // Wakeup priority in RUN and DRAIN.
    drive("pri_both", 1, 1,0,1, 0,0,0, RUN, 0, 1,0,0);
    drive("pri_aft",  1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("pri_wfi",  1, 1,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("pri_drn",  1, 0,1,1, 0,0,0, DRN, 0, 1,0,0);
    drive("pri_back", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    // Multiplier start pulse and hold tail.
    drive("mul0", 1, 0,0,0, 0,1,0, RUN, 0, 1,0,1);
    for (int i = 1; i < 5; i++)
      drive($sformatf("mul%0d", i), 1, 0,0,0, 0,0,0, RUN, 0, 1,0,H);
    drive("mul5", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("mul6", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    // Register file activity pulse and hold tail.
    drive("rf0", 1, 0,0,0, 1,0,0, RUN, 0, 1,1,0);
    for (int i = 1; i < 5; i++)
      drive($sformatf("rf%0d", i), 1, 0,0,0, 0,0,0, RUN, 0, 1,H,0);
    drive("rf5", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    // Multiplier busy for two cycles, hold counts from the last busy cycle.
    drive("busy0", 1, 0,0,0, 0,0,1, RUN, 0, 1,0,1);
    drive("busy1", 1, 0,0,0, 0,0,1, RUN, 0, 1,0,1);
    for (int i = 2; i < 6; i++)
      drive($sformatf("busy%0d", i), 1, 0,0,0, 0,0,0, RUN, 0, 1,0,H);
    drive("busy6", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    // mul_start together with wfi_req: hold survives into DRAIN.
    drive("mw0", 1, 1,0,0, 0,1,0, RUN, 0, 1,0,1);
    for (int i = 1; i < 5; i++)
      drive($sformatf("mw%0d", i), 1, 0,0,0, 0,0,0, DRN, 0, 1,0,H);
    drive("mw5", 1, 0,0,0, 0,0,0, DRN, 0, 1,0,0);
    drive("mw6", 1, 0,0,1, 0,0,0, DRN, 0, 1,0,0);
    drive("mw7", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    // Reset while asleep.
    drive("rs0", 1, 1,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("rs1", 1, 0,1,0, 0,0,0, DRN, 0, 1,0,0);
    drive("rs2", 1, 0,0,0, 0,0,0, SLP, 1, 0,0,0);
    drive("rs3", 0, 0,0,0, 0,0,0, SLP, 1, 1,1,1);
    drive("rs4", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);
    drive("rs5", 1, 0,0,0, 0,0,0, RUN, 0, 1,0,0);

    @(negedge f_clk);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
